// File: rtl/rv_pkg.sv
// rv_pkg: opcode constants, NOP encoding and fetch FSM states shared across the core.
// FETCH_MISALIGN_CHK_EN adds the FAULT state.
package rv_pkg;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;
  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
  localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_VALID
`ifdef FETCH_MISALIGN_CHK_EN
    , S_FAULT
`endif
  } fetch_state_e;
endpackage

// File: rtl/pc_next.sv
// pc_next: next-PC select (redirect, pc+4 or hold) with fetch-address alignment check.
// FETCH_MISALIGN_CHK_EN keeps redirect low bits and reports misalignment; otherwise they are cleared.
module pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            adv_i,
  input  logic            redir_i,
  input  logic [XLEN-1:0] redir_pc_i,
  output logic [XLEN-1:0] pc_nxt_o
`ifdef FETCH_MISALIGN_CHK_EN
  , output logic          mis_o
`endif
);
  logic [XLEN-1:0] tgt;
`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt   = redir_pc_i;
  assign mis_o = |pc_nxt_o[1:0];
`else
  assign tgt = redir_pc_i & ~XLEN'(3);
`endif
  assign pc_nxt_o = redir_i ? tgt : adv_i ? pc_i + XLEN'(4) : pc_i;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and instruction-memory requester feeding decode.
// FETCH_MISALIGN_CHK_EN traps misaligned redirect targets in a FAULT state.
module instr_fetch
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid_d,
  output logic [31:0]     instr_out_d,
  output logic [XLEN-1:0] pc_out_d,
  output logic [6:0]      opcode_out_d,
  output logic            misalign_d
);
  fetch_state_e    state_q, state_d, go;
  logic [XLEN-1:0] pc_q, pc_d, pout_q, pout_d;
  logic [31:0]     instr_q, instr_d;
  logic            vld_q, vld_d, mis_q, mis_d, adv, redir;
  assign redir = redirect_valid && state_q != S_IDLE;
`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_nxt;
  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc_i(pc_q), .adv_i(adv), .redir_i(redir), .redir_pc_i(redirect_pc),
    .pc_nxt_o(pc_d), .mis_o(mis_nxt)
  );
  assign go = mis_nxt ? S_FAULT : S_REQ;
`else
  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc_i(pc_q), .adv_i(adv), .redir_i(redir), .redir_pc_i(redirect_pc),
    .pc_nxt_o(pc_d)
  );
  assign go = S_REQ;
`endif
  assign imem_req_valid = state_q == S_REQ;
  assign imem_req_addr  = pc_q;
  assign instr_valid_d  = vld_q;
  assign instr_out_d    = instr_q;
  assign pc_out_d       = pout_q;
  assign opcode_out_d   = instr_q[6:0];
  assign misalign_d     = mis_q;
  always_comb begin
    state_d = state_q;
    vld_d   = redir ? 1'b0 : vld_q;
    mis_d   = redir ? 1'b0 : mis_q;
    instr_d = instr_q;
    pout_d  = pout_q;
    adv     = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   state_d = redir ? (imem_req_ready ? S_DRAIN : go) : (imem_req_ready ? S_WAIT : S_REQ);
      S_WAIT: begin
        if (redir) state_d = imem_rsp_valid ? go : S_DRAIN;
        else if (imem_rsp_valid) begin
          state_d = S_VALID;
          vld_d   = 1'b1;
          instr_d = imem_rsp_data;
          pout_d  = pc_q;
        end
      end
      S_VALID: begin
        if (redir) state_d = go;
        else if (!stall) begin
          state_d = S_REQ;
          vld_d   = 1'b0;
          adv     = 1'b1;
        end
      end
      S_DRAIN: state_d = imem_rsp_valid ? go : S_DRAIN;
`ifdef FETCH_MISALIGN_CHK_EN
      S_FAULT: state_d = redir ? go : S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHK_EN
    // A drain that finishes on a misaligned pc enters FAULT just like a direct redirect.
    if (state_d == S_FAULT && (redir || state_q == S_DRAIN)) begin
      vld_d   = 1'b1;
      mis_d   = 1'b1;
      instr_d = NOP_INSTR;
      pout_d  = pc_d;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      pout_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pout_q  <= pout_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench with a latency-programmable memory model and an
// expected-instruction scoreboard for instr_fetch.
module tb_instr_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        instr_valid_d;
  logic [31:0] instr_out_d, pc_out_d;
  logic [6:0]  opcode_out_d;
  logic        misalign_d;
  int checks = 0, failures = 0, lat = 1, n;
  typedef struct {logic [31:0] a; int c;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  mreq_t mq[$];
  exp_t  eq[$];
  instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid_d(instr_valid_d), .instr_out_d(instr_out_d), .pc_out_d(pc_out_d),
    .opcode_out_d(opcode_out_d), .misalign_d(misalign_d)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_006F : {a[24:0], 7'b0010111};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic fire, rspd;
    logic [31:0] a;
    imem_rsp_valid = mq.size() > 0 && mq[0].c <= 0;
    imem_rsp_data  = imem_rsp_valid ? mem(mq[0].a) : 32'h0;
    #1;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    rspd = imem_rsp_valid;
    @(posedge clk);
    @(negedge clk);
    if (rspd) void'(mq.pop_front());
    foreach (mq[i]) mq[i].c--;
    if (fire) mq.push_back('{a, lat - 1});
    imem_rsp_valid = 1'b0;
  endtask
  task automatic wait_valid(output int cnt);
    exp_t e;
    cnt = 0;
    while (!instr_valid_d && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("valid_timeout", {31'b0, instr_valid_d}, 32'h1);
    if (eq.size() == 0) chk("sb_empty", 32'h0, 32'h1);
    else begin
      e = eq.pop_front();
      chk("sb_pc", pc_out_d, e.pc);
      chk("sb_instr", instr_out_d, e.instr);
      chk("sb_opcode", {25'b0, opcode_out_d}, {25'b0, e.instr[6:0]});
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rqv"}, {31'b0, imem_req_valid}, 32'h0);
    chk({tag, "_vld"}, {31'b0, instr_valid_d}, 32'h0);
    chk({tag, "_mis"}, {31'b0, misalign_d}, 32'h0);
    chk({tag, "_instr"}, instr_out_d, 32'h0000_0013);
    chk({tag, "_opc"}, {25'b0, opcode_out_d}, 32'h13);
    chk({tag, "_pc"}, pc_out_d, 32'h0);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst");
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0;
    chk("idle_redir_ignored", imem_req_addr, 32'h0);
    chk("req_valid", {31'b0, imem_req_valid}, 32'h1);
    eq.push_back('{32'h0, mem(32'h0)});
    wait_valid(n);
    chk("first_latency", n, 2);
    chk("jal_opcode", {25'b0, opcode_out_d}, 32'h6F);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vld", {31'b0, instr_valid_d}, 32'h1);
      chk("stall_instr", instr_out_d, 32'h6F);
      chk("stall_pc", pc_out_d, 32'h0);
      chk("stall_rqv", {31'b0, imem_req_valid}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("consume_addr", imem_req_addr, 32'h4);
    chk("consume_vld", {31'b0, instr_valid_d}, 32'h0);
    eq.push_back('{32'h4, mem(32'h4)});
    wait_valid(n);
    chk("steady_latency", n, 2);
    lat = 3;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("drain_rqv", {31'b0, imem_req_valid}, 32'h0);
    tick();
    chk("drain_hold", {31'b0, imem_req_valid}, 32'h0);
    tick();
    chk("drain_done_rqv", {31'b0, imem_req_valid}, 32'h1);
    chk("drain_done_addr", imem_req_addr, 32'h100);
    chk("drain_vld", {31'b0, instr_valid_d}, 32'h0);
    lat = 1;
    eq.push_back('{32'h100, mem(32'h100)});
    wait_valid(n);
    chk("after_drain_latency", n, 2);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("rsp_redir_vld", {31'b0, instr_valid_d}, 32'h0);
    chk("rsp_redir_addr", imem_req_addr, 32'h200);
    chk("rsp_redir_rqv", {31'b0, imem_req_valid}, 32'h1);
    eq.push_back('{32'h200, mem(32'h200)});
    wait_valid(n);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("valid_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("valid_redir_vld", {31'b0, instr_valid_d}, 32'h0);
    eq.push_back('{32'hFFFF_FFFC, mem(32'hFFFF_FFFC)});
    wait_valid(n);
    tick();
    chk("wrap_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_flag", {31'b0, misalign_d}, 32'h1);
    chk("mis_pc", pc_out_d, 32'h102);
    chk("mis_vld", {31'b0, instr_valid_d}, 32'h1);
    chk("mis_instr", instr_out_d, 32'h0000_0013);
    chk("mis_rqv", {31'b0, imem_req_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("unfault_mis", {31'b0, misalign_d}, 32'h0);
`else
    chk("mis_tied", {31'b0, misalign_d}, 32'h0);
`endif
    chk("aligned_addr", imem_req_addr, 32'h100);
    chk("aligned_rqv", {31'b0, imem_req_valid}, 32'h1);
    imem_req_ready = 1'b1;
    eq.push_back('{32'h100, mem(32'h100)});
    wait_valid(n);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    chk("midrst_addr", imem_req_addr, 32'h0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rerun_addr", imem_req_addr, 32'h0);
    eq.push_back('{32'h0, mem(32'h0)});
    wait_valid(n);
    chk("rerun_latency", n, 2);
    chk("sb_drained", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle RISC-V core. Holds the PC, requests instructions over a valid/ready instruction-memory port, and captures each response. It presents the instruction, its PC and its opcode field to decode. `opcode_out_d` drives `control_gen` directly, and redirects from JAL/branch resolution re-steer the PC.

## Interface
Parameters:
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  XLEN  fetch address (current PC)
- `imem_rsp_valid`  in  1  response data valid (one per accepted request, in order)
- `imem_rsp_data`  in  32  fetched instruction word
- `redirect_valid`  in  1  PC redirect (taken JAL/JALR/branch)
- `redirect_pc`  in  XLEN  redirect target
- `stall`  in  1  decode cannot accept the held instruction
- `instr_valid_d`  out  1  `instr_out_d`/`pc_out_d` valid
- `instr_out_d`  out  32  fetched instruction
- `pc_out_d`  out  XLEN  PC of `instr_out_d`
- `opcode_out_d`  out  7  `instr_out_d[6:0]`, feeds `control_gen`
- `misalign_d`  out  1  fetch-address-misaligned flag (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN, VALID, plus FAULT when the macro is defined.
- Reset values:
  - state=IDLE, pc=RESET_PC, `imem_req_valid`=0, `instr_valid_d`=0, `misalign_d`=0
  - `instr_out_d`=32'h0000_0013 (NOP), `opcode_out_d`=7'b0010011, `pc_out_d`=RESET_PC
- State behaviour:
  - IDLE: moves to REQ on the next clock unconditionally.
  - REQ: `imem_req_valid`=1, `imem_req_addr`=pc. Moves to WAIT when `imem_req_ready`=1.
  - WAIT: on `imem_rsp_valid`, registers the instruction, latches pc into `pc_out_d`, sets `instr_valid_d`=1 and moves to VALID.
  - VALID: holds outputs while `stall`=1. When `stall`=0, sets pc<=pc+4, clears `instr_valid_d` and moves to REQ.
  - DRAIN: waits for the outstanding response, discards it, then moves to REQ.
- Redirect (`redirect_valid`=1) has priority over every event outside IDLE. It sets pc<=`redirect_pc`, clears `instr_valid_d` and discards any held instruction.
  - From REQ without handshake, VALID or FAULT: next state REQ.
  - From REQ with `imem_req_ready`=1 in the same cycle: next state DRAIN, because the request was already accepted.
  - From WAIT without `imem_rsp_valid`: next state DRAIN.
  - From WAIT with `imem_rsp_valid` in the same cycle: the response is dropped and the next state is REQ.
  - From DRAIN: pc is updated and the state stays DRAIN; a later redirect overwrites pc again.
- Redirect is ignored in IDLE.
- Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- `opcode_out_d` always equals `instr_out_d[6:0]`.
- Reset asserted mid-operation returns all state and outputs to reset values immediately. A response arriving after reset release, for a request accepted before reset, is a system error and is out of scope.

## Timing
- All outputs are registered except `imem_req_valid` and `imem_req_addr`, which decode combinationally from state/pc.
- Zero-wait memory (ready=1, response the cycle after acceptance):
  - Request accepted at cycle N, response at N+1, `instr_valid_d` rises at edge N+2.
  - Steady-state throughput is one instruction per 3 cycles.
- A redirect at cycle N puts `imem_req_addr`=`redirect_pc` at cycle N+1 when no drain is needed.
- `instr_valid_d` stays high until the edge after `stall`=0 or a redirect.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 issues no fetch and enters FAULT.
  - FAULT outputs: `instr_valid_d`=1, `misalign_d`=1, `instr_out_d`=NOP, `pc_out_d`=`redirect_pc`.
  - FAULT is held until the next redirect.
  - If a drain is pending, the drain completes first, then FAULT is entered.
- Not defined: `redirect_pc[1:0]` is forced to 2'b00 and `misalign_d` is tied to 0.

## Structure
- Shared package `rv_pkg`:
  - opcode constants `OPC_JAL`, `OPC_LUI`, `OPC_AUIPC`, `OPC_OPIMM`
  - `NOP_INSTR` = 32'h0000_0013
  - fetch state enum typedef
- One sub-module `pc_next`: combinational next-PC mux selecting pc+4, `redirect_pc` or hold, with the alignment check.

## Test plan
- Reset release with `RESET_PC`=0 and a zero-wait memory returning 32'h0000_006F at address 0 -> `instr_valid_d`=1 at cycle 3 with `pc_out_d`=0 and `opcode_out_d`=7'b1101111 (JAL).
- `stall`=1 for 5 cycles in VALID -> outputs held unchanged. Then `stall`=0 -> next `imem_req_addr`=32'h4.
- Redirect to 32'h100 in WAIT, with the response arriving 2 cycles later -> that response is discarded and the next request address is 32'h100.
- Redirect in the same cycle as `imem_rsp_valid` -> no `instr_valid_d` pulse, and the next request is to `redirect_pc`.
- pc=32'hFFFF_FFFC, consumed -> next `imem_req_addr`=32'h0.
- Redirect to 32'h102:
  - With `FETCH_MISALIGN_CHK_EN`: `misalign_d`=1, `pc_out_d`=32'h102, no request issued.
  - Without it: `imem_req_addr`=32'h100.
